// File: rtl/pe_bus_pkg.sv
// Shared definitions for the PE command/data bus: PE opcodes, host command encodings and
// driver FSM states.
package pe_bus_pkg;

  localparam int CTRL_W = 3;
  localparam int OP_W   = 2;

  localparam logic [CTRL_W-1:0] PE_NOP      = 3'd0;
  localparam logic [CTRL_W-1:0] PE_LOAD_WGT = 3'd1;
  localparam logic [CTRL_W-1:0] PE_LOAD_IN  = 3'd2;
  localparam logic [CTRL_W-1:0] PE_COMPUTE  = 3'd3;

  localparam logic [OP_W-1:0] OP_LOAD_WGT = 2'd0;
  localparam logic [OP_W-1:0] OP_LOAD_IN  = 2'd1;
  localparam logic [OP_W-1:0] OP_COMPUTE  = 2'd2;
  localparam logic [OP_W-1:0] OP_READ     = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_COMPUTE,
    ST_TURN,
    ST_READ,
    ST_DONE
  } state_t;

  // Only the two load commands ever stream words onto the bus.
  function automatic logic [CTRL_W-1:0] op_to_ctrl(input logic [OP_W-1:0] op);
    return (op == OP_LOAD_IN) ? PE_LOAD_IN : PE_LOAD_WGT;
  endfunction

endpackage

// File: rtl/pe_bus_driver_if.sv
// Host-side command, write-word and read-result handshakes of the PE bus driver.
interface pe_bus_driver_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) ();
  import pe_bus_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_act;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_act, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_act, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/pe_bus_rd_skid.sv
// One-entry result holding register: a load wins over a pop, so a word can leave and a new
// one arrive on the same edge.
module pe_bus_rd_skid
  import pe_bus_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_bus_driver.sv
// Host-side master for one PE's shared bus: turns command descriptors and write words into
// PE bus cycles and returns PE results through a one-entry holding register.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | cmd_ready high, waiting for a descriptor
// ST_WRITE   | streaming LOAD_WGT/LOAD_IN words onto Data, one per wr_valid
// ST_COMPUTE | Ctrl=COMPUTE held for MAC_LAT cycles
// ST_TURN    | one-cycle bus turnaround before and after a READ burst
// ST_READ    | requesting PE words with OutputCtrl and capturing them
// ST_DONE    | one cycle of quiet bus before returning to idle
module pe_bus_driver
  import pe_bus_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 6,
  parameter int RD_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_b,
  pe_bus_driver_if.slave    host,
  output logic [CTRL_W-1:0] ctrl,
  output logic              output_ctrl,
  output logic              enable_act,
  inout  wire  [DATA_W-1:0] data,
  output logic              busy
);

  localparam int TMR_MAX = (MAC_LAT > RD_LAT) ? MAC_LAT : RD_LAT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_MAC = TMR_W'(MAC_LAT - 1);
  localparam logic [TMR_W-1:0] TMR_RD  = TMR_W'(RD_LAT);

  state_t            state, state_n;
  logic [OP_W-1:0]   op_q, op_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [LEN_W:0]    cnt, cnt_n, cnt_inc;
  logic [TMR_W-1:0]  tmr, tmr_n;
  logic [CTRL_W-1:0] ctrl_n;
  logic              oe_q, oe_n;
  logic [DATA_W-1:0] dout_q, dout_n;
  logic              oc_n, ea_n;
  logic              cap;
  logic              len_hit;
  logic              rd_free;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;

  assign cnt_inc = cnt + 1'b1;
  assign len_hit = (cnt == {1'b0, len_q});
  assign rd_free = !skid_valid || host.rd_ready;

  assign host.cmd_ready = (state == ST_IDLE);
  assign host.wr_ready  = (state == ST_WRITE);
  assign host.rd_valid  = skid_valid;
  assign host.rd_data   = skid_data;
  assign busy           = (state != ST_IDLE);

  assign data = oe_q ? dout_q : {DATA_W{1'bz}};

  always_comb begin
    state_n = state;
    op_n    = op_q;
    len_n   = len_q;
    cnt_n   = cnt;
    tmr_n   = tmr;
    ctrl_n  = PE_NOP;
    oe_n    = 1'b0;
    dout_n  = dout_q;
    oc_n    = 1'b0;
    ea_n    = enable_act;
    cap     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (host.cmd_valid) begin
          op_n  = host.cmd_op;
          len_n = host.cmd_len;
          cnt_n = '0;
          if (host.cmd_op == OP_COMPUTE) begin
            state_n = ST_COMPUTE;
            ctrl_n  = PE_COMPUTE;
            ea_n    = host.cmd_act;
            tmr_n   = TMR_MAC;
          end else if (host.cmd_len == '0) begin
            state_n = ST_DONE;
          end else if (host.cmd_op == OP_READ) begin
            state_n = ST_TURN;
            ea_n    = host.cmd_act;
          end else begin
            state_n = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        if (host.wr_valid) begin
          ctrl_n = op_to_ctrl(op_q);
          oe_n   = 1'b1;
          dout_n = host.wr_data;
          cnt_n  = cnt_inc;
          if (cnt_inc == {1'b0, len_q}) state_n = ST_DONE;
        end
      end

      ST_COMPUTE: begin
        if (tmr == '0) begin
          state_n = ST_DONE;
          ea_n    = 1'b0;
        end else begin
          ctrl_n = PE_COMPUTE;
          tmr_n  = tmr - 1'b1;
        end
      end

      // Entered with cnt==0 before a burst and cnt==len after it.
      ST_TURN: begin
        if (len_hit) begin
          state_n = ST_DONE;
          ea_n    = 1'b0;
        end else begin
          state_n = ST_READ;
          oc_n    = 1'b1;
          tmr_n   = TMR_RD;
        end
      end

      ST_READ: begin
        if (len_hit) begin
          if (rd_free) state_n = ST_TURN;
        end else if (output_ctrl) begin
          if (tmr == '0) begin
            cap   = 1'b1;
            cnt_n = cnt_inc;
          end else begin
            oc_n  = 1'b1;
            tmr_n = tmr - 1'b1;
          end
        end else if (rd_free) begin
          // A held word must be accepted before the PE is asked for the next one.
          oc_n  = 1'b1;
          tmr_n = TMR_RD;
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
        ea_n    = 1'b0;
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      len_q       <= '0;
      cnt         <= '0;
      tmr         <= '0;
      ctrl        <= PE_NOP;
      oe_q        <= 1'b0;
      dout_q      <= '0;
      output_ctrl <= 1'b0;
      enable_act  <= 1'b0;
    end else begin
      state       <= state_n;
      op_q        <= op_n;
      len_q       <= len_n;
      cnt         <= cnt_n;
      tmr         <= tmr_n;
      ctrl        <= ctrl_n;
      oe_q        <= oe_n;
      dout_q      <= dout_n;
      output_ctrl <= oc_n;
      enable_act  <= ea_n;
    end
  end

  pe_bus_rd_skid #(.DATA_W(DATA_W)) u_rd_skid (
    .clk       (clk),
    .rst_b     (rst_b),
    .load      (cap),
    .load_data (data),
    .ready     (host.rd_ready),
    .valid     (skid_valid),
    .data      (skid_data)
  );

  a_bus_exclusive: assert property (@(posedge clk) !(oe_q && output_ctrl));

endmodule

// File: tb/tb_pe_bus_driver.sv
// Directed bench for pe_bus_driver with a small PE read model answering RD_LAT after OutputCtrl.
module tb_pe_bus_driver;
  import pe_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  wire  [31:0] data;
  logic [2:0]  ctrl;
  logic        output_ctrl;
  logic        enable_act;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  pe_bus_driver_if #(.DATA_W(32), .LEN_W(8)) host ();

  pe_bus_driver #(.DATA_W(32), .LEN_W(8), .MAC_LAT(6), .RD_LAT(2)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .host        (host),
    .ctrl        (ctrl),
    .output_ctrl (output_ctrl),
    .enable_act  (enable_act),
    .data        (data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // PE read model: drives word pe_idx while OutputCtrl, delayed two cycles, is high.
  logic [1:0]  oc_dly;
  int          pe_idx;
  logic [31:0] pe_words [4];
  logic [31:0] pe_word;

  assign pe_word = pe_words[pe_idx % 4];
  assign data    = oc_dly[1] ? pe_word : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (!rst_b) begin
      oc_dly <= 2'b00;
      pe_idx <= 0;
    end else begin
      oc_dly <= {oc_dly[0], output_ctrl};
      if (oc_dly[1] && !oc_dly[0]) pe_idx <= pe_idx + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] len, input logic act);
    host.cmd_valid = 1'b1;
    host.cmd_op    = op;
    host.cmd_len   = len;
    host.cmd_act   = act;
    cyc();
    host.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] wv [4];
    logic [31:0] dv [5];
    logic        pat [5];
    int          n;

    wv[0] = 32'h3F80_0000; wv[1] = 32'h4000_0000;
    wv[2] = 32'h4040_0000; wv[3] = 32'h4080_0000;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
    for (int k = 0; k < 5; k++) dv[k] = 32'hA000_0000 + 32'(k);
    pe_words[0] = 32'h4120_0000; pe_words[1] = 32'h41A0_0000;
    pe_words[2] = 32'h41F0_0000; pe_words[3] = 32'h4220_0000;

    host.cmd_valid = 1'b0; host.cmd_op = 2'd0; host.cmd_len = 8'd0; host.cmd_act = 1'b0;
    host.wr_valid = 1'b0;  host.wr_data = 32'd0; host.rd_ready = 1'b0;

    // Reset state
    repeat (3) cyc();
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_oc", 32'(output_ctrl), 32'd0);
    chk("rst_ea", 32'(enable_act), 32'd0);
    chk("rst_oe", 32'(dut.oe_q), 32'd0);
    chk("rst_rd_valid", 32'(host.rd_valid), 32'd0);
    chk("rst_rd_data", host.rd_data, 32'd0);
    chk("rst_cmd_ready", 32'(host.cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_b = 1'b1;
    cyc();

    // 1: LOAD_WGT len=4, words back to back
    host.wr_valid = 1'b1;
    host.wr_data  = wv[0];
    send_cmd(OP_LOAD_WGT, 8'd4, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_cmd_ready", 32'(host.cmd_ready), 32'd0);
    chk("t1_wr_ready", 32'(host.wr_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t1_ctrl", 32'(ctrl), 32'd1);
      chk("t1_oe", 32'(dut.oe_q), 32'd1);
      chk("t1_data", data, wv[i]);
      if (i < 3) host.wr_data = wv[i+1];
    end
    host.wr_valid = 1'b0;
    chk("t1_wr_ready_done", 32'(host.wr_ready), 32'd0);
    chk("t1_cmd_ready_done", 32'(host.cmd_ready), 32'd0);
    cyc();
    chk("t1_ctrl_end", 32'(ctrl), 32'd0);
    chk("t1_oe_end", 32'(dut.oe_q), 32'd0);
    chk("t1_cmd_ready_end", 32'(host.cmd_ready), 32'd1);

    // 2: LOAD_IN len=3 with wr_valid 1,0,0,1,1
    send_cmd(OP_LOAD_IN, 8'd3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      host.wr_valid = pat[k];
      host.wr_data  = dv[k];
      cyc();
      chk("t2_ctrl", 32'(ctrl), pat[k] ? 32'd2 : 32'd0);
      chk("t2_oe", 32'(dut.oe_q), 32'(pat[k]));
      if (pat[k]) chk("t2_data", data, dv[k]);
    end
    host.wr_valid = 1'b0;
    chk("t2_busy_done", 32'(busy), 32'd1);
    cyc();
    chk("t2_ctrl_end", 32'(ctrl), 32'd0);
    chk("t2_cmd_ready_end", 32'(host.cmd_ready), 32'd1);

    // 3: COMPUTE with EnableAct, exactly six COMPUTE cycles
    send_cmd(OP_COMPUTE, 8'h55, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("t3_ctrl", 32'(ctrl), 32'd3);
      chk("t3_ea", 32'(enable_act), 32'd1);
      cyc();
    end
    chk("t3_ctrl_end", 32'(ctrl), 32'd0);
    chk("t3_ea_end", 32'(enable_act), 32'd0);
    chk("t3_busy_done", 32'(busy), 32'd1);
    cyc();
    chk("t3_cmd_ready_end", 32'(host.cmd_ready), 32'd1);

    // 4: READ len=2, first result held five cycles
    host.rd_ready = 1'b0;
    send_cmd(OP_READ, 8'd2, 1'b1);
    chk("t4_turn_oc", 32'(output_ctrl), 32'd0);
    chk("t4_turn_ea", 32'(enable_act), 32'd1);
    cyc();
    chk("t4_oc_rise", 32'(output_ctrl), 32'd1);
    cyc();
    cyc();
    chk("t4_rd_valid_early", 32'(host.rd_valid), 32'd0);
    cyc();
    chk("t4_rd_valid0", 32'(host.rd_valid), 32'd1);
    chk("t4_rd_data0", host.rd_data, 32'h4120_0000);
    chk("t4_oc_after_cap", 32'(output_ctrl), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_stall_valid", 32'(host.rd_valid), 32'd1);
      chk("t4_stall_oc", 32'(output_ctrl), 32'd0);
      chk("t4_stall_data", host.rd_data, 32'h4120_0000);
    end
    host.rd_ready = 1'b1;
    cyc();
    chk("t4_pop_valid", 32'(host.rd_valid), 32'd0);
    chk("t4_req2_oc", 32'(output_ctrl), 32'd1);
    n = 0;
    while (!host.rd_valid && n < 10) begin
      cyc();
      n++;
    end
    chk("t4_rd_lat", 32'(n), 32'd3);
    chk("t4_rd_data1", host.rd_data, 32'h41A0_0000);
    cyc();
    chk("t4_pop2_valid", 32'(host.rd_valid), 32'd0);
    chk("t4_turn_back_oc", 32'(output_ctrl), 32'd0);
    chk("t4_turn_back_ea", 32'(enable_act), 32'd1);
    cyc();
    chk("t4_done_ea", 32'(enable_act), 32'd0);
    chk("t4_done_busy", 32'(busy), 32'd1);
    cyc();
    chk("t4_cmd_ready_end", 32'(host.cmd_ready), 32'd1);
    host.rd_ready = 1'b0;

    // 5: zero-length READ and LOAD_WGT finish in two cycles with a quiet bus
    send_cmd(OP_READ, 8'd0, 1'b1);
    chk("t5r_oc", 32'(output_ctrl), 32'd0);
    chk("t5r_ea", 32'(enable_act), 32'd0);
    chk("t5r_busy", 32'(busy), 32'd1);
    cyc();
    chk("t5r_cmd_ready", 32'(host.cmd_ready), 32'd1);
    host.wr_valid = 1'b1;
    host.wr_data  = 32'hDEAD_BEEF;
    send_cmd(OP_LOAD_WGT, 8'd0, 1'b0);
    chk("t5w_ctrl", 32'(ctrl), 32'd0);
    chk("t5w_oe", 32'(dut.oe_q), 32'd0);
    chk("t5w_wr_ready", 32'(host.wr_ready), 32'd0);
    cyc();
    chk("t5w_ctrl2", 32'(ctrl), 32'd0);
    chk("t5w_cmd_ready", 32'(host.cmd_ready), 32'd1);
    host.wr_valid = 1'b0;

    // 6a: reset during word 2 of a four-word LOAD_WGT
    host.wr_valid = 1'b1;
    host.wr_data  = wv[0];
    send_cmd(OP_LOAD_WGT, 8'd4, 1'b0);
    cyc();
    host.wr_data = wv[1];
    cyc();
    chk("t6w_data_pre", data, wv[1]);
    rst_b = 1'b0;
    cyc();
    chk("t6w_ctrl", 32'(ctrl), 32'd0);
    chk("t6w_oe", 32'(dut.oe_q), 32'd0);
    chk("t6w_busy", 32'(busy), 32'd0);
    chk("t6w_cmd_ready", 32'(host.cmd_ready), 32'd1);
    host.wr_valid = 1'b0;
    rst_b = 1'b1;
    cyc();

    // 6b: reset while a READ result is held
    send_cmd(OP_READ, 8'd2, 1'b1);
    n = 0;
    while (!host.rd_valid && n < 10) begin
      cyc();
      n++;
    end
    chk("t6r_wait", 32'(n), 32'd4);
    chk("t6r_rd_data_pre", host.rd_data, 32'h4120_0000);
    rst_b = 1'b0;
    cyc();
    chk("t6r_rd_valid", 32'(host.rd_valid), 32'd0);
    chk("t6r_rd_data", host.rd_data, 32'd0);
    chk("t6r_oc", 32'(output_ctrl), 32'd0);
    chk("t6r_ea", 32'(enable_act), 32'd0);
    chk("t6r_busy", 32'(busy), 32'd0);
    rst_b = 1'b1;
    cyc();

    // 6c: fresh command after reset
    host.wr_valid = 1'b1;
    host.wr_data  = wv[2];
    send_cmd(OP_LOAD_WGT, 8'd2, 1'b0);
    cyc();
    chk("t6c_ctrl0", 32'(ctrl), 32'd1);
    chk("t6c_data0", data, wv[2]);
    host.wr_data = wv[3];
    cyc();
    chk("t6c_ctrl1", 32'(ctrl), 32'd1);
    chk("t6c_data1", data, wv[3]);
    host.wr_valid = 1'b0;
    cyc();
    chk("t6c_ctrl_end", 32'(ctrl), 32'd0);
    cyc();
    chk("t6c_cmd_ready", 32'(host.cmd_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
